// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - issue/wait/response sequencer for one FPU datapath operation at a time
module fpu_op_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int FLAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    output logic              req_ready,
    output logic              dp_start,
    output logic [1:0]        dp_op,
    input  logic              dp_done,
    input  logic [FLAG_W-1:0] dp_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              rsp_timeout,
    output logic [FLAG_W-1:0] flags_sticky,
    input  logic              flags_clr,
    input  logic [FLAG_W-1:0] irq_en,
    output logic              irq,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Abort fires when the incremented count would reach TIMEOUT-1, so the
    // response lands exactly TIMEOUT cycles after dp_start.
    localparam logic [7:0]        CNT_LAST     = 8'(TIMEOUT - 2);
    localparam logic [FLAG_W-1:0] INVALID_FLAG = FLAG_W'(1) << (FLAG_W - 1);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q;
    logic [1:0]         dp_op_q;
    logic [FLAG_W-1:0]  rsp_flags_q;
    logic               rsp_timeout_q;
    logic [FLAG_W-1:0]  sticky_q, sticky_d;
    logic               irq_q;
    logic               load_rsp;
    logic [FLAG_W-1:0]  new_flags;
    logic               new_timeout;

    always_comb begin
        state_d     = state_q;
        load_rsp    = 1'b0;
        new_flags   = dp_flags;
        new_timeout = 1'b0;
        case (state_q)
            IDLE:  if (req_valid) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (dp_done) begin
                    load_rsp = 1'b1;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    load_rsp    = 1'b1;
                    new_flags   = INVALID_FLAG;
                    new_timeout = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A clear coinciding with a capture keeps only the freshly captured flags.
    always_comb begin
        sticky_d = sticky_q;
        if (load_rsp) begin
            sticky_d = flags_clr ? new_flags : (sticky_q | new_flags);
        end else if (flags_clr) begin
            sticky_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dp_op_q       <= '0;
            rsp_flags_q   <= '0;
            rsp_timeout_q <= 1'b0;
            sticky_q      <= '0;
            irq_q         <= 1'b0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
            irq_q    <= |(sticky_q & irq_en);
            if (state_q == IDLE && req_valid) begin
                dp_op_q <= req_op;
            end
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (load_rsp) begin
                rsp_flags_q   <= new_flags;
                rsp_timeout_q <= new_timeout;
            end
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign dp_start     = (state_q == ISSUE);
    assign dp_op        = dp_op_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_flags    = rsp_flags_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign flags_sticky = sticky_q;
    assign irq          = irq_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb/tb_fpu_op_sequencer.sv - randomized self-checking bench for fpu_op_sequencer
module tb_fpu_op_sequencer;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_op;
    logic       req_ready;
    logic       dp_start;
    logic [1:0] dp_op;
    logic       dp_done;
    logic [4:0] dp_flags;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_flags;
    logic       rsp_timeout;
    logic [4:0] flags_sticky;
    logic       flags_clr;
    logic [4:0] irq_en;
    logic       irq;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [4:0] m_sticky = 5'b0;

    fpu_op_sequencer #(.TIMEOUT(TIMEOUT), .FLAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready), .dp_start(dp_start), .dp_op(dp_op),
        .dp_done(dp_done), .dp_flags(dp_flags), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
        .flags_sticky(flags_sticky), .flags_clr(flags_clr), .irq_en(irq_en),
        .irq(irq), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; req_op = 0; dp_done = 0; dp_flags = 0;
        rsp_ready = 0; flags_clr = 0; irq_en = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dp_start, dp_op, rsp_valid, rsp_flags, rsp_timeout, flags_sticky, irq, busy} !== 15'b0) begin
            errors++;
            $display("FAIL reset_outputs got start=%b op=%b rv=%b rf=%b to=%b st=%b irq=%b busy=%b exp all 0",
                     dp_start, dp_op, rsp_valid, rsp_flags, rsp_timeout, flags_sticky, irq, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        m_sticky = 5'b0;
    endtask

    // Returns at the negedge of the dp_start cycle.
    task automatic start_op(input logic [1:0] op);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b exp 1", req_ready); end
        req_valid = 1'b1; req_op = op;
        @(negedge clk);
        req_valid = 1'b0; req_op = 2'($urandom);
        checks++;
        if (dp_start !== 1'b1 || dp_op !== op) begin
            errors++; $display("FAIL issue got dp_start=%b dp_op=%b exp 1 %b", dp_start, dp_op, op);
        end
    endtask

    // d: dp_done delay after dp_start (>= TIMEOUT means it never comes in time).
    task automatic run_op(input logic [1:0] op, input int d, input logic [4:0] f,
                          input bit clr, input int hold);
        int lat;
        logic [4:0] exp_f;
        logic exp_to;
        logic exp_irq;
        exp_to = (d >= TIMEOUT);
        lat    = exp_to ? TIMEOUT : d + 1;
        exp_f  = exp_to ? 5'b10000 : f;
        start_op(op);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            dp_done = 1'b0; flags_clr = 1'b0;
            checks++;
            if (rsp_valid !== (k == lat)) begin
                errors++; $display("FAIL rsp_latency cyc %0d got rsp_valid=%b exp %b", k, rsp_valid, k == lat);
            end
            if (k == 1) begin
                checks++;
                if (dp_start !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL start_pulse got dp_start=%b busy=%b exp 0 1", dp_start, busy);
                end
            end
            if (k == d) begin dp_done = 1'b1; dp_flags = f; flags_clr = clr; end
        end
        m_sticky = clr ? exp_f : (m_sticky | exp_f);
        exp_irq  = |(m_sticky & irq_en);
        checks++;
        if (rsp_flags !== exp_f || rsp_timeout !== exp_to || flags_sticky !== m_sticky || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL response got flags=%b to=%b sticky=%b ready=%b exp %b %b %b 0",
                     rsp_flags, rsp_timeout, flags_sticky, req_ready, exp_f, exp_to, m_sticky);
        end
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_op = 2'($urandom);
            dp_done = 1'b1; dp_flags = 5'b11111;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_flags !== exp_f || rsp_timeout !== exp_to ||
                req_ready !== 1'b0 || flags_sticky !== m_sticky) begin
                errors++;
                $display("FAIL resp_hold got rv=%b flags=%b to=%b ready=%b sticky=%b exp 1 %b %b 0 %b",
                         rsp_valid, rsp_flags, rsp_timeout, req_ready, flags_sticky, exp_f, exp_to, m_sticky);
            end
            if (h == 0) begin
                checks++;
                if (irq !== exp_irq) begin errors++; $display("FAIL irq got %b exp %b", irq, exp_irq); end
            end
        end
        dp_done = 1'b0;
        rsp_ready = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || dp_start !== 1'b0) begin
            errors++;
            $display("FAIL handshake got rv=%b busy=%b ready=%b start=%b exp 0 0 1 0", rsp_valid, busy, req_ready, dp_start);
        end
        if (hold == 0) begin
            checks++;
            if (irq !== exp_irq) begin errors++; $display("FAIL irq got %b exp %b", irq, exp_irq); end
        end
    endtask

    task automatic test_directed();
        irq_en = 5'b00000;
        run_op(2'b00, 2, 5'b00001, 1'b0, 1);
        run_op(2'b11, TIMEOUT + 4, 5'b00000, 1'b0, 1);
        run_op(2'b01, TIMEOUT - 1, 5'b00010, 1'b0, 0);
        run_op(2'b10, 1, 5'b00100, 1'b0, 0);
    endtask

    task automatic test_irq_accumulate();
        @(negedge clk); flags_clr = 1'b1;
        @(negedge clk); flags_clr = 1'b0;
        m_sticky = 5'b0;
        @(negedge clk);
        checks++;
        if (flags_sticky !== 5'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL clear_alone got sticky=%b irq=%b exp 00000 0", flags_sticky, irq);
        end
        irq_en = 5'b00100;
        run_op(2'b10, 3, 5'b00100, 1'b0, 0);
        run_op(2'b00, 2, 5'b00010, 1'b0, 0);
        checks++;
        if (flags_sticky !== 5'b00110 || irq !== 1'b1) begin
            errors++; $display("FAIL sticky_accum got sticky=%b irq=%b exp 00110 1", flags_sticky, irq);
        end
    endtask

    task automatic test_clear_on_capture();
        irq_en = 5'b00001;
        run_op(2'b00, 2, 5'b00001, 1'b1, 0);
        run_op(2'b01, 4, 5'b01000, 1'b1, 0);
        checks++;
        if (flags_sticky !== 5'b01000 || irq !== 1'b0) begin
            errors++; $display("FAIL clear_capture got sticky=%b irq=%b exp 01000 0", flags_sticky, irq);
        end
    endtask

    task automatic test_back_pressure();
        run_op(2'b11, 5, 5'b00011, 1'b0, 10);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            irq_en = 5'($urandom);
            run_op(2'($urandom), int'($urandom_range(1, TIMEOUT + 3)), 5'($urandom),
                   1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid();
        if (m_sticky == 5'b0) run_op(2'b00, 2, 5'b00001, 1'b0, 0);
        start_op(2'b11);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_sticky = 5'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || dp_op !== 2'b00 || flags_sticky !== 5'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got busy=%b rv=%b op=%b sticky=%b irq=%b exp 0 0 00 00000 0",
                     busy, rsp_valid, dp_op, flags_sticky, irq);
        end
        @(negedge clk);
        rst_n = 1'b1; dp_done = 1'b1; dp_flags = 5'b01111;
        @(negedge clk);
        dp_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || flags_sticky !== 5'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_done got rv=%b sticky=%b ready=%b busy=%b exp 0 00000 1 0",
                         rsp_valid, flags_sticky, req_ready, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_irq_accumulate();
        test_clear_on_capture();
        test_back_pressure();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
